// File: rtl/serial_ripple_subtractor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_ripple_subtractor : bit-serial term1 - term2, one bit per clock,
// LSB first, through a single full-subtractor cell and a registered borrow.
// Revision: 1.0
// ----------------------------------------------------------------------------
module serial_ripple_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_sub_term1,
  input  logic [WIDTH-1:0] i_sub_term2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result
);

  localparam int              CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);
  localparam logic [1:0]      S_IDLE = 2'd0;
  localparam logic [1:0]      S_RUN  = 2'd1;
  localparam logic [1:0]      S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_a_shift;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_result;
  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic             w_accept;

  assign w_a_bit   = r_a[0];
  assign w_b_bit   = r_b[0];
  assign w_d       = w_a_bit ^ w_b_bit ^ r_borrow;
  assign w_br_next = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_borrow);
  assign w_last    = (r_cnt == C_LAST);
  assign w_accept  = (r_state == S_IDLE) && i_valid;

  // The minuend register doubles as the difference register: each consumed
  // LSB frees an MSB slot that receives the new difference bit.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_a_shift = w_d;
    end else begin : g_wn
      assign w_a_shift = {w_d, r_a[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_valid) w_state_next = S_RUN;
      S_RUN:   if (w_last)  w_state_next = S_DONE;
      S_DONE:  if (i_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (r_state == S_IDLE);
    o_valid = (r_state == S_DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a      <= i_sub_term1;
      r_b      <= i_sub_term2;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_a      <= w_a_shift;
      r_b      <= r_b >> 1;
      r_borrow <= w_br_next;
      r_cnt    <= r_cnt + 1'b1;
      // Result is captured separately so it stays stable outside DONE.
      if (w_last) begin
        r_result <= {w_br_next, w_a_shift};
      end
    end
  end

  assign o_result = r_result;

endmodule
`default_nettype wire
